// File: rtl/onehot_regfile.sv
// 16-entry register file written through a one-hot select vector, with two
// registered read ports, optional write bypass and a sticky malformed-write flag.
module onehot_regfile #(
  parameter int unsigned WIDTH   = 16,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      wr_sel,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       wr_count
);

  logic [WIDTH-1:0] r_mem [16];
  logic [WIDTH-1:0] r_rdDataA;
  logic [WIDTH-1:0] r_rdDataB;
  logic             r_rdValid;
  logic             r_err;
  logic [7:0]       r_wrCount;

  logic             w_oneHot;
  logic             w_accept;
  logic             w_bad;
  logic [WIDTH-1:0] w_rdA;
  logic [WIDTH-1:0] w_rdB;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign w_oneHot = (wr_sel != 16'd0) && ((wr_sel & (wr_sel - 16'd1)) == 16'd0);
  assign w_accept = wr_en && w_oneHot;
  assign w_bad    = wr_en && !w_oneHot;

  always_comb begin
    w_rdA = r_mem[rd_addr_a];
    w_rdB = r_mem[rd_addr_b];
    if (BYPASS && w_accept && wr_sel[rd_addr_a]) begin
      w_rdA = wr_data;
    end
    if (BYPASS && w_accept && wr_sel[rd_addr_b]) begin
      w_rdB = wr_data;
    end
    if (R0_ZERO && (rd_addr_a == 4'd0)) begin
      w_rdA = '0;
    end
    if (R0_ZERO && (rd_addr_b == 4'd0)) begin
      w_rdB = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < 16; i++) begin
        if (wr_sel[i] && !(R0_ZERO && (i == 0))) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdDataA <= '0;
      r_rdDataB <= '0;
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= rd_req;
      if (rd_req) begin
        r_rdDataA <= w_rdA;
        r_rdDataB <= w_rdB;
      end
    end
  end

  // A malformed write takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_wrCount <= 8'd0;
    end else begin
      if (w_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_accept) begin
        r_wrCount <= r_wrCount + 8'd1;
      end
    end
  end

  assign rd_data_a = r_rdDataA;
  assign rd_data_b = r_rdDataB;
  assign rd_valid  = r_rdValid;
  assign err       = r_err;
  assign wr_count  = r_wrCount;

endmodule
